// File: rtl/sha256_pkg.sv
// sha256_pkg: shared word width, hash size, FSM state encoding and byte-swap helper.
package sha256_pkg;
    localparam int WORD_W = 32;
    localparam int HASH_WORDS = 8;
    typedef logic [WORD_W-1:0] word_t;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    function automatic word_t bswap(word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/load_hash_capture.sv
// load_hash_capture: delays the read strobe/address by one cycle and writes returning words into hash_vector.
// Define LOAD_HASH_BSWAP_EN to byte-reverse each word before it is stored.
module load_hash_capture
    import sha256_pkg::*;
#(
    parameter int HASH_LENGTH = HASH_WORDS
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic                              h_read,
    input  logic [$clog2(HASH_LENGTH)-1:0]    h_address,
    input  logic [WORD_W-1:0]                 h_data,
    output logic                              cap_en,
    output logic [HASH_LENGTH*WORD_W-1:0]     hash_vector
);
    localparam int AW = $clog2(HASH_LENGTH);
    logic [AW-1:0] cap_addr;
    word_t word;
`ifdef LOAD_HASH_BSWAP_EN
    assign word = bswap(h_data);
`else
    assign word = h_data;
`endif
    // enable low kills both the pending strobe and the word arriving this cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cap_en      <= 1'b0;
            cap_addr    <= '0;
            hash_vector <= '0;
        end else begin
            cap_en   <= h_read & enable;
            cap_addr <= h_address;
            for (int w = 0; w < HASH_LENGTH; w++)
                if (cap_en && enable && cap_addr == AW'(w))
                    hash_vector[w*WORD_W +: WORD_W] <= word;
        end
    end
endmodule

// File: rtl/load_hash.sv
// load_hash: reads HASH_LENGTH words from H memory and assembles them into hash_vector.
// Define LOAD_HASH_BSWAP_EN to byte-reverse words for little-endian memory images.
module load_hash
    import sha256_pkg::*;
#(
    parameter int HASH_LENGTH = HASH_WORDS
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic                              start,
    output logic                              h_read,
    output logic [$clog2(HASH_LENGTH)-1:0]    h_address,
    input  logic [WORD_W-1:0]                 h_data,
    output logic                              busy,
    output logic [HASH_LENGTH*WORD_W-1:0]     hash_vector,
    output logic                              hash_valid
);
    localparam int AW = $clog2(HASH_LENGTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST = CW'(HASH_LENGTH - 1);
    state_t state;
    logic [CW-1:0] rd_cnt, wr_cnt;
    logic cap_en;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            h_read     <= 1'b0;
            h_address  <= '0;
            busy       <= 1'b0;
            hash_valid <= 1'b0;
        end else if (!enable) begin
            state      <= IDLE;
            h_read     <= 1'b0;
            busy       <= 1'b0;
            hash_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state      <= ISSUE;
                    rd_cnt     <= '0;
                    wr_cnt     <= '0;
                    busy       <= 1'b1;
                    hash_valid <= 1'b0;
                end
                ISSUE: begin
                    h_read    <= 1'b1;
                    h_address <= rd_cnt[AW-1:0];
                    rd_cnt    <= rd_cnt + 1'b1;
                    if (cap_en) wr_cnt <= wr_cnt + 1'b1;
                    if (rd_cnt == LAST) state <= DRAIN;
                end
                DRAIN: begin
                    h_read <= 1'b0;
                    // valid only once the final word of this load is being written
                    if (cap_en) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == LAST) begin
                            state      <= DONE;
                            hash_valid <= 1'b1;
                            busy       <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    load_hash_capture #(.HASH_LENGTH(HASH_LENGTH)) u_capture (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .h_read      (h_read),
        .h_address   (h_address),
        .h_data      (h_data),
        .cap_en      (cap_en),
        .hash_vector (hash_vector)
    );
endmodule

// File: tb/tb_load_hash.sv
// tb_load_hash: table-driven and randomized checks of load_hash (HASH_LENGTH 8 and 5) against a memory model.
module tb_load_hash;
    logic clock = 1'b0, reset_n, enable, start, start5;
    logic h_read, h_read5, busy, busy5, hash_valid, valid5;
    logic [2:0] h_address, h_address5;
    logic [31:0] h_data, h_data5;
    logic [255:0] hash_vector;
    logic [159:0] hv5;
    logic [31:0] mem [8];
    int pass_cnt = 0, total = 0, reads8 = 0, reads5 = 0;

    typedef struct { bit st; bit en; bit rd; int addr; bit bsy; bit vld; } vec_t;
    vec_t tbl [11];

    always #5 clock = ~clock;

    load_hash #(.HASH_LENGTH(8)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .start(start), .h_read(h_read),
        .h_address(h_address), .h_data(h_data), .busy(busy), .hash_vector(hash_vector), .hash_valid(hash_valid)
    );
    load_hash #(.HASH_LENGTH(5)) dut5 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .start(start5), .h_read(h_read5),
        .h_address(h_address5), .h_data(h_data5), .busy(busy5), .hash_vector(hv5), .hash_valid(valid5)
    );

    // synchronous memory: data appears the cycle after the strobe
    always @(posedge clock) begin
        h_data  <= h_read  ? mem[h_address]  : 32'h0;
        h_data5 <= h_read5 ? mem[h_address5] : 32'h0;
    end
    always @(negedge clock) begin
        if (h_read)  reads8++;
        if (h_read5) reads5++;
    end

    function automatic logic [31:0] sw(logic [31:0] w);
`ifdef LOAD_HASH_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [255:0] model(int hl);
        logic [255:0] v = '0;
        for (int a = 0; a < hl; a++) v[a*32 +: 32] = sw(mem[a]);
        return v;
    endfunction

    task automatic check(string name, logic [255:0] got, logic [255:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic fill(logic [31:0] base);
        for (int a = 0; a < 8; a++) mem[a] = base + a;
    endtask

    task automatic run_table(bit mid_pulse);
        int r0;
        logic [255:0] exp;
        r0 = reads8;
        exp = model(8);
        for (int k = 0; k < 11; k++) begin
            start = tbl[k].st | (mid_pulse && k == 4);
            enable = tbl[k].en;
            step(1);
            check($sformatf("busy[%0d]", k), busy, tbl[k].bsy);
            check($sformatf("valid[%0d]", k), hash_valid, tbl[k].vld);
            check($sformatf("h_read[%0d]", k), h_read, tbl[k].rd);
            if (tbl[k].rd) check($sformatf("addr[%0d]", k), h_address, tbl[k].addr);
        end
        start = 1'b0;
        check("read_count", reads8 - r0, 8);
        check("vector", hash_vector, exp);
    endtask

    initial begin
        logic [255:0] old_v, part;
        int r0;
        tbl[0] = '{1, 1, 0, 0, 1, 0};
        for (int k = 1; k <= 8; k++) tbl[k] = '{0, 1, 1, k - 1, 1, 0};
        tbl[9]  = '{0, 1, 0, 7, 1, 0};
        tbl[10] = '{0, 1, 0, 7, 0, 1};
        reset_n = 1'b0; enable = 1'b0; start = 1'b0; start5 = 1'b0;
        fill(32'h1000_0000);
        #12;
        check("rst_h_read", h_read, 0);
        check("rst_addr", h_address, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", hash_valid, 0);
        check("rst_vector", hash_vector, 0);
        @(posedge clock); #1;
        reset_n = 1'b1; enable = 1'b1;
        step(2);
        run_table(0);
        // back-to-back from DONE with new contents
        fill(32'hA5A5_0000);
        run_table(0);
        // start pulsed mid-ISSUE is ignored
        fill(32'h1000_0000);
        run_table(1);
        // enable dropped after the 4th read
        old_v = model(8);
        fill(32'h5555_0000);
        part = old_v;
        part[63:0] = model(2);
        start = 1'b1; step(1); start = 1'b0;
        step(4);
        check("drop_rd", h_read, 1);
        check("drop_addr", h_address, 3);
        enable = 1'b0;
        step(1);
        check("drop_h_read", h_read, 0);
        check("drop_busy", busy, 0);
        check("drop_valid", hash_valid, 0);
        step(10);
        check("drop_valid_late", hash_valid, 0);
        check("drop_partial", hash_vector, part);
        run_table(0);
        // randomized contents, gaps and stray starts
        for (int i = 0; i < 10; i++) begin
            for (int a = 0; a < 8; a++) mem[a] = $urandom;
            step($urandom_range(0, 3));
            run_table(1'($urandom_range(0, 1)));
        end
        // async reset mid-DRAIN
        start = 1'b1; step(1); start = 1'b0;
        step(9);
        check("drain_h_read", h_read, 0);
        check("drain_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", hash_valid, 0);
        check("arst_vector", hash_vector, 0);
        check("arst_addr", h_address, 0);
        step(2);
        reset_n = 1'b1;
        step(12);
        check("arst_valid_late", hash_valid, 0);
        check("arst_busy_late", busy, 0);
        // HASH_LENGTH = 5 instance
        fill(32'h1000_0000);
        r0 = reads5;
        start5 = 1'b1; step(1); start5 = 1'b0;
        check("hl5_busy", busy5, 1);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            check($sformatf("hl5_rd[%0d]", k), h_read5, 1);
            check($sformatf("hl5_addr[%0d]", k), h_address5, k - 1);
        end
        step(1);
        check("hl5_drain_valid", valid5, 0);
        check("hl5_drain_rd", h_read5, 0);
        step(1);
        check("hl5_valid", valid5, 1);
        check("hl5_busy_done", busy5, 0);
        check("hl5_vector", hv5, model(5));
        check("hl5_reads", reads5 - r0, 5);
`ifdef LOAD_HASH_BSWAP_EN
        mem[0] = 32'h0123_4567;
        run_table(0);
        check("bswap_word0", hash_vector[31:0], 32'h6745_2301);
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
